// File: rtl/switch_input_port.sv
// Debounced, CPU-handshaked capture of the 16-bit board switches.
// One qualified press of btn_enter yields exactly one word on data_out.
module switch_input_port #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] switch,
  input  logic        btn_enter,
  input  logic        req,
  input  logic        ack,
  output logic [31:0] data_out,
  output logic        data_valid,
  output logic [2:0]  estado
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    DEBOUNCE = 3'd2,
    VALID    = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  state_t           state_q;
  logic             btn_meta_q;
  logic             btn_s_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      data_q;
  logic             valid_q;

  // The counter serves both the press qualification (DEBOUNCE) and the
  // release qualification (RELEASE); it is cleared on entry to each.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      btn_meta_q <= 1'b0;
      btn_s_q    <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      btn_meta_q <= btn_enter;
      btn_s_q    <= btn_meta_q;
      case (state_q)
        IDLE: begin
          valid_q <= 1'b0;
          if (req) state_q <= ARMED;
        end
        ARMED: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (btn_s_q) begin
            state_q <= DEBOUNCE;
            cnt_q   <= '0;
          end
        end
        DEBOUNCE: begin
          if (!req) begin
            state_q <= IDLE;
          end else if (!btn_s_q) begin
            state_q <= ARMED;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= VALID;
            data_q  <= switch;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        VALID: begin
          // ack wins over a simultaneous req drop: the word was consumed.
          if (ack) begin
            state_q <= RELEASE;
            valid_q <= 1'b0;
            cnt_q   <= '0;
          end else if (!req) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        RELEASE: begin
          if (btn_s_q) begin
            cnt_q <= '0;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = {16'b0, data_q};
  assign data_valid = valid_q;
  assign estado     = state_q;

endmodule

// File: tb/tb_switch_input_port.sv
// Directed bench for switch_input_port (N=4) with a press/release age model
// compared every cycle, plus literal checkpoints.
module tb_switch_input_port;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] switch;
  logic        btn_enter;
  logic        req;
  logic        ack;
  logic [31:0] data_out;
  logic        data_valid;
  logic [2:0]  estado;

  int n_vec = 0;
  int n_err = 0;

  switch_input_port #(.DEBOUNCE_CYCLES(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .switch    (switch),
    .btn_enter (btn_enter),
    .req       (req),
    .ack       (ack),
    .data_out  (data_out),
    .data_valid(data_valid),
    .estado    (estado)
  );

  always #5 clk = ~clk;

  // Model: phases of a transaction, with press age (consecutive synchronized
  // high samples while waiting for a press) and release age (consecutive
  // synchronized low samples after the word was consumed).
  localparam int P_IDLE = 0, P_WAIT = 1, P_WORD = 2, P_REL = 3;
  int          m_phase;
  int          m_press_age;
  int          m_rel_age;
  logic        m_sync1, m_sync2;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b0;

  function automatic logic [2:0] m_estado();
    case (m_phase)
      P_IDLE:  return 3'd0;
      P_WAIT:  return (m_press_age == 0) ? 3'd1 : 3'd2;
      P_WORD:  return 3'd3;
      default: return 3'd4;
    endcase
  endfunction

  initial forever begin
    logic bs;
    @(posedge clk);
    if (reset) begin
      m_phase = P_IDLE; m_press_age = 0; m_rel_age = 0;
      m_sync1 = 1'b0; m_sync2 = 1'b0; m_data = '0; m_valid = 1'b0;
      m_ready = 1'b1;
    end else if (m_ready) begin
      bs = m_sync2;
      case (m_phase)
        P_IDLE: begin
          m_press_age = 0;
          if (req) m_phase = P_WAIT;
        end
        P_WAIT: begin
          if (!req) m_phase = P_IDLE;
          else if (bs) begin
            m_press_age++;
            if (m_press_age == N + 1) begin
              m_phase = P_WORD; m_valid = 1'b1; m_data = {16'h0000, switch};
            end
          end else m_press_age = 0;
        end
        P_WORD: begin
          if (ack) begin
            m_phase = P_REL; m_valid = 1'b0; m_rel_age = 0;
          end else if (!req) begin
            m_phase = P_IDLE; m_valid = 1'b0;
          end
        end
        default: begin
          m_rel_age = bs ? 0 : m_rel_age + 1;
          if (m_rel_age == N) m_phase = P_IDLE;
        end
      endcase
      m_sync2 = m_sync1;
      m_sync1 = btn_enter;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (m_ready) begin
      chk("model data_out", data_out, m_data);
      chk("model data_valid", {31'b0, data_valid}, {31'b0, m_valid});
      chk("model estado", {29'b0, estado}, {29'b0, m_estado()});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press with req held until VALID (N+3 edges after the button goes high).
  task automatic press_capture(input logic [15:0] sw);
    switch = sw; req = 1'b1; btn_enter = 1'b1;
    tick(N + 3);
  endtask

  task automatic release_btn();
    btn_enter = 1'b0;
    tick(N + 3);
  endtask

  initial begin
    reset = 1'b1; switch = '0; btn_enter = 1'b0; req = 1'b0; ack = 1'b0;
    tick(3);
    chk("reset estado", {29'b0, estado}, 32'd0);
    chk("reset data_valid", {31'b0, data_valid}, 32'd0);
    chk("reset data_out", data_out, 32'd0);
    reset = 1'b0;

    // ack in IDLE is ignored
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("ack in idle", {29'b0, estado}, 32'd0);

    // clean press with exact latency
    req = 1'b1; switch = 16'h00A5;
    tick(2);
    chk("armed", {29'b0, estado}, 32'd1);
    btn_enter = 1'b1;
    tick(6);
    chk("latency k+5 not valid", {31'b0, data_valid}, 32'd0);
    tick(1);
    chk("latency k+6 valid", {31'b0, data_valid}, 32'd1);
    chk("captured word", data_out, 32'h000000A5);
    chk("valid estado", {29'b0, estado}, 32'd3);

    // switch changes do not disturb the held word
    switch = 16'hFFFF;
    tick(3);
    chk("stable data_out", data_out, 32'h000000A5);

    // consume, then hold the button with req still high
    ack = 1'b1; tick(1); ack = 1'b0;
    chk("ack clears valid", {31'b0, data_valid}, 32'd0);
    chk("ack to release", {29'b0, estado}, 32'd4);
    tick(50);
    chk("hold stays release", {29'b0, estado}, 32'd4);
    chk("hold no word", {31'b0, data_valid}, 32'd0);
    btn_enter = 1'b0;
    tick(6);
    chk("release to idle", {29'b0, estado}, 32'd0);
    tick(1);
    chk("idle to armed", {29'b0, estado}, 32'd1);

    // bounce rejection
    switch = 16'h1234;
    btn_enter = 1'b1; tick(2); btn_enter = 1'b0; tick(3);
    btn_enter = 1'b1; tick(2); btn_enter = 1'b0; tick(5);
    chk("bounce no valid", {31'b0, data_valid}, 32'd0);
    chk("bounce back armed", {29'b0, estado}, 32'd1);
    chk("bounce keeps old word", data_out, 32'h000000A5);

    // abort during debounce
    btn_enter = 1'b1; tick(4);
    chk("in debounce", {29'b0, estado}, 32'd2);
    req = 1'b0; tick(1);
    chk("abort debounce idle", {29'b0, estado}, 32'd0);
    btn_enter = 1'b0; tick(4);
    chk("abort no capture", data_out, 32'h000000A5);

    // reset while VALID discards the word
    press_capture(16'h5A5A);
    chk("second word", data_out, 32'h00005A5A);
    reset = 1'b1; req = 1'b0; btn_enter = 1'b0; tick(1);
    chk("reset in valid dv", {31'b0, data_valid}, 32'd0);
    chk("reset in valid data", data_out, 32'd0);
    reset = 1'b0; req = 1'b1; tick(N + 4);
    chk("no pulse after reset", {31'b0, data_valid}, 32'd0);

    // ack with simultaneous req drop -> RELEASE
    press_capture(16'h0F0F);
    chk("third word", data_out, 32'h00000F0F);
    ack = 1'b1; req = 1'b0; tick(1); ack = 1'b0;
    chk("ack priority", {29'b0, estado}, 32'd4);
    release_btn();
    chk("ack priority idle", {29'b0, estado}, 32'd0);

    // abort in VALID keeps data_out
    press_capture(16'hC3C3);
    req = 1'b0; tick(1);
    chk("abort valid idle", {29'b0, estado}, 32'd0);
    chk("abort valid dv", {31'b0, data_valid}, 32'd0);
    chk("abort valid keeps data", data_out, 32'h0000C3C3);
    release_btn();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
